// File: rtl/fft32_pkg.sv
// Shared constants, types and helpers for the 32-point FFT datapath.
package fft32_pkg;

    localparam int N_POINTS = 32;
    localparam int IDX_W    = 5;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE,
        STREAM
    } ser_state_t;

    // Mirror the bin number so bit 0 becomes bit 4, bit 1 becomes bit 3, and so on.
    function automatic idx_t bitrev5(input idx_t v);
        idx_t r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft32_out_serializer_if.sv
// Frame-load and output-stream signals of the FFT output serializer.
interface fft32_out_serializer_if
    import fft32_pkg::*;
#(
    parameter int OUT_ELEMENT_LENGTH = 16
);

    logic                                   EN_OUT;
    logic [N_POINTS*OUT_ELEMENT_LENGTH-1:0] fft_re;
    logic [N_POINTS*OUT_ELEMENT_LENGTH-1:0] fft_im;
    logic                                   out_ready;
    logic                                   out_valid;
    logic [OUT_ELEMENT_LENGTH-1:0]          out_re;
    logic [OUT_ELEMENT_LENGTH-1:0]          out_im;
    idx_t                                   out_index;
    logic                                   out_last;
    logic                                   busy;
    logic                                   overrun;

    // The serializer owns the output stream; the datapath and the sink drive the rest.
    modport master (
        input  EN_OUT, fft_re, fft_im, out_ready,
        output out_valid, out_re, out_im, out_index, out_last, busy, overrun
    );

    modport slave (
        output EN_OUT, fft_re, fft_im, out_ready,
        input  out_valid, out_re, out_im, out_index, out_last, busy, overrun
    );

endinterface

// File: rtl/fft32_out_serializer.sv
// Captures a full 32-point FFT frame in one cycle and streams it one complex
// sample per beat, optionally converting bit-reversed order to natural order.
module fft32_out_serializer
    import fft32_pkg::*;
#(
    parameter int OUT_ELEMENT_LENGTH = 16,
    parameter bit BIT_REVERSE        = 1'b1
) (
    input logic                    clk2,
    input logic                    rst,
    fft32_out_serializer_if.master bus
);

    localparam int   W        = OUT_ELEMENT_LENGTH;
    localparam idx_t LAST_IDX = idx_t'(N_POINTS - 1);

    ser_state_t     state_q, state_d;
    idx_t           idx_q, idx_d;
    logic           overrun_q, overrun_d;
    logic [W-1:0]   buf_re_q [N_POINTS];
    logic [W-1:0]   buf_im_q [N_POINTS];

    logic xfer;
    logic final_xfer;
    logic load;
    idx_t src_idx;

    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        xfer       = (state_q == STREAM) && bus.out_ready;
        final_xfer = xfer && (idx_q == LAST_IDX);
        load       = bus.EN_OUT && ((state_q == IDLE) || final_xfer);
        state_d    = state_q;
        idx_d      = idx_q;
        overrun_d  = overrun_q;

        if (load) begin
            state_d = STREAM;
            idx_d   = '0;
        end else if (final_xfer) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (xfer) begin
            idx_d = idx_q + idx_t'(1);
        end

        // A strobe that could not be honoured is remembered until reset.
        if (bus.EN_OUT && !load) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            // NOTE: the frame buffer is reset because its entries reach the outputs directly.
            for (int k = 0; k < N_POINTS; k++) begin
                buf_re_q[k] <= '0;
                buf_im_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            if (load) begin
                for (int k = 0; k < N_POINTS; k++) begin
                    buf_re_q[k] <= bus.fft_re[k*W +: W];
                    buf_im_q[k] <= bus.fft_im[k*W +: W];
                end
            end
        end
    end

    assign src_idx = BIT_REVERSE ? bitrev5(idx_q) : idx_q;

    // All outputs come from state, idx and buffer registers only.
    assign bus.out_valid = (state_q == STREAM);
    assign bus.busy      = (state_q == STREAM);
    assign bus.out_index = idx_q;
    assign bus.out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
    assign bus.out_re    = buf_re_q[src_idx];
    assign bus.out_im    = buf_im_q[src_idx];
    assign bus.overrun   = overrun_q;

endmodule

// File: doc/fft32_out_serializer.md
# fft32_out_serializer

Output-side unloader for the 32-point FFT datapath. It captures the 32 complex FFT results in one cycle when the datapath's completion strobe fires. It then streams them out one complex sample per beat over a valid/ready interface, optionally reordering from bit-reversed to natural order. It sits after the final butterfly stage and is the counterpart to the parallel input register at the datapath front end.

## Interface
- `OUT_ELEMENT_LENGTH`, default 16: width of each signed real or imaginary output element.
- `BIT_REVERSE`, default 1: 1 means the captured frame is in bit-reversed order and is emitted in natural order; 0 means it is emitted in capture order.
- `clk2` input, 1 bit: single clock; all logic is on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `EN_OUT` input, 1 bit: load strobe from the FFT datapath; capture the frame this cycle.
- `fft_re` input, 32*OUT_ELEMENT_LENGTH bits: packed signed real parts; element k is at `[k*W +: W]`.
- `fft_im` input, 32*OUT_ELEMENT_LENGTH bits: packed signed imaginary parts, same packing.
- `out_ready` input, 1 bit: downstream ready to accept.
- `out_valid` output, 1 bit: current beat is valid.
- `out_re` output, OUT_ELEMENT_LENGTH bits: signed real part of the current sample.
- `out_im` output, OUT_ELEMENT_LENGTH bits: signed imaginary part of the current sample.
- `out_index` output, 5 bits: natural-order frequency bin of the current beat.
- `out_last` output, 1 bit: high on beat 31 of the frame.
- `busy` output, 1 bit: a frame is held or streaming; equals `out_valid`.
- `overrun` output, 1 bit: sticky flag; a load was dropped.

## Operation
- **States:**
  - IDLE: `out_valid` is 0.
  - STREAM: `out_valid` is 1.
- **IDLE with `EN_OUT`=1:**
  - Capture all 64 elements into the frame buffer.
  - Set the beat counter `idx` to 0.
  - Go to STREAM.
- **STREAM, current beat:**
  - `out_index` = `idx`.
  - The source element is `bitrev5(idx)` if BIT_REVERSE=1, otherwise `idx`.
  - `out_re` and `out_im` are the buffer entries at that source element.
  - `out_last` = (`idx` == 31).
- **Handshake:** a beat transfers when `out_valid` and `out_ready` are both 1.
  - Transfer with `idx` < 31: increment `idx`.
  - Transfer with `idx` == 31 and `EN_OUT`=0: go to IDLE and clear `idx` to 0.
  - Transfer with `idx` == 31 and `EN_OUT`=1: capture the new frame, set `idx` to 0, and stay in STREAM. Back-to-back frames have no bubble.
- **`EN_OUT`=1 in STREAM without a final transfer:**
  - The load is ignored.
  - `overrun` goes to 1 and stays at 1 until reset.
  - The current frame is unaffected.
- **`out_ready` low:** all outputs hold stable. Valid is never withdrawn before the transfer.
- **Widths:** no arithmetic on sample data; elements pass bit-exact. `idx` is 5 bits and never wraps except through the rules above.
- **Outputs:** driven only from registers (state, `idx`, buffer).
  - No combinational path from `EN_OUT`, `fft_re` or `fft_im` to any output.
  - No combinational path from `out_ready` to any output.

## Timing
- **Reset values:** `out_valid`, `out_re`, `out_im`, `out_index`, `out_last`, `busy` and `overrun` are all 0; the buffer is all 0; state is IDLE.
- **Reset mid-frame:** the frame is discarded immediately and asynchronously, and no partial beats follow.
- **Load latency:** `EN_OUT` sampled at edge t gives `out_valid`=1 with beat 0 from edge t onward, i.e. visible in cycle t+1.
- **Throughput:** one beat per cycle with `out_ready` held high. A frame takes exactly 32 cycles. Frame period is 32 cycles minimum.
- **`EN_OUT`:** treated as a single-cycle pulse; a level held high reloads per the rules above each cycle.

## Structure
- Shared package `fft32_pkg` holds:
  - `N_POINTS` = 32 and `IDX_W` = 5.
  - The `ser_state_t` enum (IDLE, STREAM).
  - The function `bitrev5`.
- The frame buffer is two 32-entry register arrays, one real and one imaginary.
- The output mux is indexed by the mapped `idx`.
- No sub-module; a single module is natural.

## Test plan
1. **Natural order:** after reset, BIT_REVERSE=0, `fft_re[k]`=k and `fft_im[k]`=-k, one `EN_OUT` pulse, `out_ready`=1.
   - 32 consecutive beats with `out_index` 0..31, `out_re`=k and `out_im`=-k.
   - `out_last` only on beat 31; `out_valid` is 0 the cycle after.
2. **Bit-reversed:** same stimulus with BIT_REVERSE=1.
   - Beat i carries element `bitrev5(i)`: beat 1 has `out_re`=16, beat 3 has `out_re`=24, beat 31 has `out_re`=31.
3. **Backpressure:** `out_ready` pattern 1,0,1,0,...
   - Data, index and last are stable across every ready-low cycle.
   - 32 transfers complete in 63 cycles.
4. **Overrun:** a second `EN_OUT` with different data during beat 10.
   - Stream continues with the original values.
   - `overrun`=1 from the next cycle and stays at 1 through the following frame.
5. **Back-to-back:** `EN_OUT` coincident with the beat-31 transfer.
   - Beat 0 of the new frame appears in the next cycle, with `out_valid` continuously 1.
   - `overrun` stays 0.
6. **Reset mid-frame:** `rst` pulsed at beat 7.
   - All outputs are 0 immediately.
   - A subsequent load streams the new frame from beat 0 with `overrun`=0.
